// File: rtl/pcileech_cpl_pkg.sv
// Shared types and constants for the config-space completion generator.
package pcileech_cpl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_HDR0,
    ST_HDR1,
    ST_HDR2,
    ST_DATA
  } cpl_state_e;

  localparam logic [2:0]  CPL_SC   = 3'b000;
  localparam logic [2:0]  CPL_UR   = 3'b001;

  localparam logic [31:0] DW0_CPLD = 32'h4A00_0001;
  localparam logic [31:0] DW0_CPL  = 32'h0A00_0000;

  localparam logic [1:0]  TP_NONE  = 2'b00;
  localparam logic [1:0]  TP_CFGRD = 2'b01;
  localparam logic [1:0]  TP_CFGWR = 2'b10;
  localparam logic [1:0]  TP_UNSUP = 2'b11;

  typedef struct packed {
    logic [1:0]  tp;
    logic        tlpwr;
    logic [7:0]  tag;
    logic [15:0] reqid;
    logic [31:0] data;
  } cpl_entry_t;

  // Only a supported, non-write request returns a payload dword.
  function automatic logic cpl_has_data(cpl_entry_t e);
    return (e.tp != TP_UNSUP) && !e.tlpwr;
  endfunction

  function automatic logic [31:0] cpl_dw0(cpl_entry_t e);
    return cpl_has_data(e) ? DW0_CPLD : DW0_CPL;
  endfunction

endpackage

// File: rtl/pcileech_cplgen_fifo.sv
// Show-ahead synchronous FIFO; a write while full is accepted only with a simultaneous read.
module pcileech_cplgen_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 59
) (
  input  logic                       clk_pcie,
  input  logic                       rst_n,
  input  logic                       wr_en,
  input  logic [WIDTH-1:0]           wr_data,
  input  logic                       rd_en,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             wr_ok;
  logic             rd_ok;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign count   = wr_ptr - rd_ptr;
  assign rd_ok   = rd_en && !empty;
  assign wr_ok   = wr_en && (!full || rd_ok);
  assign rd_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk_pcie) begin
    if (wr_ok) mem[wr_ptr[AW-1:0]] <= wr_data;
  end

  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (rd_ok) rd_ptr <= rd_ptr + 1'b1;
    end
  end

endmodule

// File: rtl/pcileech_cfgspace_cpl_gen.sv
// Buffers config-space read results and streams them out as Cpl/CplD TLPs
// over a 32-bit valid/ready interface.
module pcileech_cfgspace_cpl_gen
  import pcileech_cpl_pkg::*;
#(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk_pcie,
  input  logic             rst_n,
  input  logic [1:0]       rd_tp,
  input  logic             rd_tlpwr,
  input  logic [7:0]       rd_tag,
  input  logic [15:0]      rd_reqid,
  input  logic [31:0]      rd_data,
  input  logic [7:0]       pcie_bus_number,
  input  logic [4:0]       pcie_device_number,
  input  logic [2:0]       pcie_function_number,
  output logic             cpl_ready,
  output logic [31:0]      tx_tdata,
  output logic             tx_tvalid,
  output logic             tx_tlast,
  input  logic             tx_tready,
  output logic [CNT_W-1:0] cpl_count,
  output logic [7:0]       drop_count,
  output logic             overflow
);

  localparam int unsigned AW = $clog2(DEPTH);

  cpl_entry_t  push_entry;
  cpl_entry_t  head;
  cpl_entry_t  hold;
  logic        push;
  logic        push_ok;
  logic        pop;
  logic        drop;
  logic        fifo_full;
  logic        fifo_empty;
  logic [AW:0] fifo_count;
  logic [AW:0] occ_next;

  cpl_state_e  state;
  cpl_state_e  state_n;
  logic        hs;
  logic        done;
  logic [31:0] tdata_n;
  logic        tvalid_n;
  logic        tlast_n;
  logic [31:0] dw1;
  logic [31:0] dw2;
  logic [2:0]  status;

  assign push       = (rd_tp != TP_NONE);
  assign push_entry = '{tp: rd_tp, tlpwr: rd_tlpwr, tag: rd_tag, reqid: rd_reqid, data: rd_data};
  assign push_ok    = push && (!fifo_full || pop);
  assign drop       = push && fifo_full && !pop;
  assign occ_next   = fifo_count + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop};

  pcileech_cplgen_fifo #(
    .DEPTH (DEPTH),
    .WIDTH ($bits(cpl_entry_t))
  ) u_fifo (
    .clk_pcie (clk_pcie),
    .rst_n    (rst_n),
    .wr_en    (push),
    .wr_data  (push_entry),
    .rd_en    (pop),
    .rd_data  (head),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count)
  );

  assign status = (hold.tp == TP_UNSUP) ? CPL_UR : CPL_SC;
  assign dw1    = {pcie_bus_number, pcie_device_number, pcie_function_number,
                   status, 1'b0, 12'd4};
  assign dw2    = {hold.reqid, hold.tag, 1'b0, 7'd0};
  assign hs     = tx_tvalid && tx_tready;

  always_comb begin
    state_n  = state;
    pop      = 1'b0;
    done     = 1'b0;
    tdata_n  = tx_tdata;
    tvalid_n = tx_tvalid;
    tlast_n  = tx_tlast;
    case (state)
      ST_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_n = ST_HDR0;
        end
      end
      // Entered from IDLE with nothing presented yet: load DW0 first.
      ST_HDR0: begin
        if (!tx_tvalid) begin
          tdata_n  = cpl_dw0(hold);
          tvalid_n = 1'b1;
          tlast_n  = 1'b0;
        end else if (tx_tready) begin
          state_n = ST_HDR1;
          tdata_n = dw1;
        end
      end
      ST_HDR1: begin
        if (hs) begin
          state_n = ST_HDR2;
          tdata_n = dw2;
          tlast_n = !cpl_has_data(hold);
        end
      end
      ST_HDR2: begin
        if (hs) begin
          if (cpl_has_data(hold)) begin
            state_n = ST_DATA;
            tdata_n = hold.data;
            tlast_n = 1'b1;
          end else begin
            done = 1'b1;
          end
        end
      end
      ST_DATA: begin
        if (hs) done = 1'b1;
      end
      default: state_n = ST_IDLE;
    endcase

    // Back-to-back: DW0 of the next entry comes straight from the FIFO head.
    if (done) begin
      if (!fifo_empty) begin
        pop      = 1'b1;
        state_n  = ST_HDR0;
        tdata_n  = cpl_dw0(head);
        tvalid_n = 1'b1;
        tlast_n  = 1'b0;
      end else begin
        state_n  = ST_IDLE;
        tdata_n  = '0;
        tvalid_n = 1'b0;
        tlast_n  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk_pcie or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      hold       <= '0;
      tx_tdata   <= '0;
      tx_tvalid  <= 1'b0;
      tx_tlast   <= 1'b0;
      cpl_ready  <= 1'b1;
      cpl_count  <= '0;
      drop_count <= '0;
      overflow   <= 1'b0;
    end else begin
      state     <= state_n;
      tx_tdata  <= tdata_n;
      tx_tvalid <= tvalid_n;
      tx_tlast  <= tlast_n;
      cpl_ready <= (occ_next <= (AW + 1)'(DEPTH - 2));
      if (pop) hold <= head;
      if (done) cpl_count <= cpl_count + CNT_W'(1);
      if (drop) begin
        overflow <= 1'b1;
        if (drop_count != 8'hFF) drop_count <= drop_count + 8'd1;
      end
    end
  end

endmodule
